// File: rtl/hub_slot_sched.sv
// -----------------------------------------------------------------------------
// hub_slot_sched
//
// Time-slot scheduler for a shared hub bus serving eight cogs. A phase flop
// produces one bus strobe every two clocks. On each strobe the slot owner
// (bus_sel) advances, either as a plain 8-slot rotation or skipping cogs that
// are not running. A cog that is requesting and owns the slot is granted.
// Its result comes back on done exactly two strobes later. The scheduler also
// keeps per-cog wait statistics: the current wait in strobes, and the largest
// wait seen at grant time.
//
// Ports
//   clk_cog   in   1  sole clock, rising edge
//   res       in   1  asynchronous active-high reset
//   cog_ena   in   8  cog n running when bit n = 1
//   req       in   8  cog n has a pending hub operation (held until done)
//   cfg_skip  in   1  0 = fixed rotation, 1 = skip disabled cogs
//   wait_sel  in   3  cog index selected for wait_q
//   wait_clr  in   1  clears all max-wait registers on a strobe
//   ena_bus   out  1  hub bus strobe (phase flop)
//   bus_sel   out  8  one-hot owner of the current slot
//   grant     out  8  one-hot, operation accepted this strobe
//   done      out  8  one-hot, operation result available
//   wait_q    out  8  maximum recorded wait of cog wait_sel, in strobes
// -----------------------------------------------------------------------------
module hub_slot_sched (
  input  logic       clk_cog,
  input  logic       res,
  input  logic [7:0] cog_ena,
  input  logic [7:0] req,
  input  logic       cfg_skip,
  input  logic [2:0] wait_sel,
  input  logic       wait_clr,
  output logic       ena_bus,
  output logic [7:0] bus_sel,
  output logic [7:0] grant,
  output logic [7:0] done,
  output logic [7:0] wait_q
);

  // ---------------------------------------------------------------------------
  // Next slot owner. bus_sel is always one-hot, so the candidate is rotated one
  // position at a time and the first enabled position wins. The eighth rotation
  // lands back on the current owner, which keeps a lone enabled cog in place.
  // With no cog enabled, or with skipping off, the result is a plain rotate.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] next_slot(
    input logic [7:0] cur,
    input logic [7:0] ena,
    input logic       skip
  );
    logic [7:0] cand;
    logic [7:0] nxt;
    logic       found;
    nxt   = {cur[6:0], cur[7]};
    cand  = cur;
    found = 1'b0;
    if (skip && (ena != 8'h00)) begin
      for (int k = 0; k < 8; k++) begin
        cand = {cand[6:0], cand[7]};
        if (!found && ((cand & ena) != 8'h00)) begin
          nxt   = cand;
          found = 1'b1;
        end else begin
          nxt   = nxt;
        end
      end
    end else begin
      nxt = {cur[6:0], cur[7]};
    end
    return nxt;
  endfunction

  // Saturating increment for the 8-bit wait counters.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'd255) begin
      r = 8'd255;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic       phase_r;
  logic [7:0] bus_sel_r;
  logic [7:0] p1_r;
  logic [7:0] p2_r;
  logic [7:0] wait_cnt_r [8];
  logic [7:0] max_r      [8];

  logic [7:0] bus_sel_nxt_s;
  logic [7:0] grant_s;
  logic [7:0] wait_cnt_nxt_s [8];
  logic [7:0] max_nxt_s      [8];

  // Phase flop: toggles every clock; its high half is the bus strobe.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      phase_r <= 1'b0;
    end else begin
      phase_r <= ~phase_r;
    end
  end

  // Grant is only meaningful while the strobe is high.
  always_comb begin
    grant_s = 8'h00;
    if (phase_r) begin
      grant_s = bus_sel_r & req & cog_ena;
    end else begin
      grant_s = 8'h00;
    end
  end

  // Slot advance for the next strobe; a cfg_skip change applies right here.
  always_comb begin
    bus_sel_nxt_s = next_slot(bus_sel_r, cog_ena, cfg_skip);
  end

  // Per-cog wait statistics for the next strobe. A granted cog publishes its
  // wait (if it is a new maximum) and restarts; a waiting enabled requester
  // counts up; anything else restarts. wait_clr overrides any max update.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      wait_cnt_nxt_s[n] = 8'h00;
      max_nxt_s[n]      = max_r[n];
      if (grant_s[n]) begin
        wait_cnt_nxt_s[n] = 8'h00;
        if (wait_cnt_r[n] > max_r[n]) begin
          max_nxt_s[n] = wait_cnt_r[n];
        end else begin
          max_nxt_s[n] = max_r[n];
        end
      end else if (req[n] && cog_ena[n]) begin
        wait_cnt_nxt_s[n] = sat_inc(wait_cnt_r[n]);
      end else begin
        wait_cnt_nxt_s[n] = 8'h00;
      end
      if (wait_clr) begin
        max_nxt_s[n] = 8'h00;
      end else begin
        max_nxt_s[n] = max_nxt_s[n];
      end
    end
  end

  // Slot state: advances only on strobe clocks and holds otherwise. The
  // pipeline is deliberately unaffected by cog_ena/cfg_skip so that an
  // in-flight result always returns; only reset discards it.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      bus_sel_r <= 8'b0000_0001;
      p1_r      <= 8'h00;
      p2_r      <= 8'h00;
      for (int n = 0; n < 8; n++) begin
        wait_cnt_r[n] <= 8'h00;
        max_r[n]      <= 8'h00;
      end
    end else if (phase_r) begin
      bus_sel_r <= bus_sel_nxt_s;
      p1_r      <= grant_s;
      p2_r      <= p1_r;
      for (int n = 0; n < 8; n++) begin
        wait_cnt_r[n] <= wait_cnt_nxt_s[n];
        max_r[n]      <= max_nxt_s[n];
      end
    end else begin
      bus_sel_r <= bus_sel_r;
      p1_r      <= p1_r;
      p2_r      <= p2_r;
      for (int n = 0; n < 8; n++) begin
        wait_cnt_r[n] <= wait_cnt_r[n];
        max_r[n]      <= max_r[n];
      end
    end
  end

  // Outputs: done is gated by the strobe so it pulses once per result.
  assign ena_bus = phase_r;
  assign bus_sel = bus_sel_r;
  assign grant   = grant_s;
  assign done    = phase_r ? p2_r : 8'h00;
  assign wait_q  = max_r[wait_sel];

endmodule

// File: tb/tb_hub_slot_sched.sv
// -----------------------------------------------------------------------------
// tb_hub_slot_sched
//
// Directed scenarios followed by randomized traffic, all checked against a
// reference model that tracks the slot owner as an integer index, the result
// pipeline as two grant snapshots and the wait statistics as integer arrays.
// -----------------------------------------------------------------------------
module tb_hub_slot_sched;

  logic       clk_cog = 1'b0;
  logic       res = 1'b1;
  logic [7:0] cog_ena = 8'h00;
  logic [7:0] req = 8'h00;
  logic       cfg_skip = 1'b0;
  logic [2:0] wait_sel = 3'd0;
  logic       wait_clr = 1'b0;
  logic       ena_bus;
  logic [7:0] bus_sel;
  logic [7:0] grant;
  logic [7:0] done;
  logic [7:0] wait_q;

  hub_slot_sched dut (
    .clk_cog  (clk_cog),
    .res      (res),
    .cog_ena  (cog_ena),
    .req      (req),
    .cfg_skip (cfg_skip),
    .wait_sel (wait_sel),
    .wait_clr (wait_clr),
    .ena_bus  (ena_bus),
    .bus_sel  (bus_sel),
    .grant    (grant),
    .done     (done),
    .wait_q   (wait_q)
  );

  always #5 clk_cog = ~clk_cog;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Inputs to apply at the next falling edge.
  logic       n_res = 1'b1;
  logic [7:0] n_ena = 8'h00;
  logic [7:0] n_req = 8'h00;
  logic       n_skip = 1'b0;
  logic [2:0] n_sel = 3'd0;
  logic       n_clr = 1'b0;

  // Outputs seen in the most recent step.
  logic [7:0] obs_bus, obs_grant, obs_done, obs_wq;

  // Reference model.
  int         m_phase;
  int         m_owner;
  logic [7:0] m_p1, m_p2;
  int         m_cnt [8];
  int         m_max [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_p1 = 8'h00;
    m_p2 = 8'h00;
    for (int n = 0; n < 8; n++) begin
      m_cnt[n] = 0;
      m_max[n] = 0;
    end
  endtask

  function automatic int next_owner(input int o, input logic [7:0] ena, input logic skip);
    int r;
    r = (o + 1) % 8;
    if (skip && ena != 8'h00) begin
      for (int k = 8; k >= 1; k--) begin
        if (ena[(o + k) % 8]) r = (o + k) % 8;
      end
    end
    return r;
  endfunction

  task automatic model_advance(input logic [7:0] g);
    if (m_phase == 1) begin
      m_owner = next_owner(m_owner, cog_ena, cfg_skip);
      for (int n = 0; n < 8; n++) begin
        if (g[n]) begin
          if (m_cnt[n] > m_max[n]) m_max[n] = m_cnt[n];
          m_cnt[n] = 0;
        end else if (req[n] && cog_ena[n]) begin
          m_cnt[n] = (m_cnt[n] >= 255) ? 255 : m_cnt[n] + 1;
        end else begin
          m_cnt[n] = 0;
        end
        if (wait_clr) m_max[n] = 0;
      end
      m_p2 = m_p1;
      m_p1 = g;
    end
    m_phase = 1 - m_phase;
  endtask

  // One clock: drive at the falling edge, check shortly after, advance model.
  task automatic step();
    logic [7:0] e_bus, e_grant, e_done;
    @(negedge clk_cog);
    res = n_res; cog_ena = n_ena; req = n_req;
    cfg_skip = n_skip; wait_sel = n_sel; wait_clr = n_clr;
    #1;
    if (res) model_reset();
    e_bus   = 8'h01 << m_owner;
    e_grant = (m_phase == 1) ? (e_bus & req & cog_ena) : 8'h00;
    e_done  = (m_phase == 1) ? m_p2 : 8'h00;
    check("ena_bus", {31'd0, ena_bus}, m_phase);
    check("bus_sel", {24'd0, bus_sel}, {24'd0, e_bus});
    check("grant",   {24'd0, grant},   {24'd0, e_grant});
    check("done",    {24'd0, done},    {24'd0, e_done});
    check("wait_q",  {24'd0, wait_q},  m_max[wait_sel]);
    obs_bus = bus_sel; obs_grant = grant; obs_done = done; obs_wq = wait_q;
    if (!res) model_advance(e_grant);
    cyc++;
  endtask

  task automatic do_reset();
    n_res = 1'b1;
    step();
    step();
    n_res = 1'b0;
  endtask

  initial begin
    int t_grant;
    int n_done;
    int found;

    model_reset();

    // Reset state and fixed rotation with no requests.
    n_ena = 8'hFF; n_req = 8'h00; n_skip = 1'b0;
    do_reset();
    check("rst_bus_sel", {24'd0, obs_bus}, 32'h01);
    check("rst_wait_q",  {24'd0, obs_wq},  32'h00);
    for (int i = 0; i < 34; i++) step();

    // Skip mode with a sparse enable mask, then with nothing enabled.
    n_skip = 1'b1; n_ena = 8'b0010_0101;
    for (int i = 0; i < 16; i++) step();
    n_ena = 8'h00;
    for (int i = 0; i < 20; i++) step();
    n_ena = 8'h10;
    for (int i = 0; i < 8; i++) step();

    // Grant-to-done latency for cog 3 in fixed mode.
    n_skip = 1'b0; n_ena = 8'hFF;
    do_reset();
    n_req = 8'h08;
    t_grant = -100; n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (obs_grant[3]) begin
        t_grant = cyc;
        check("grant3_slot", {24'd0, obs_bus}, 32'h08);
      end
      if (obs_done[3]) begin
        n_done++;
        check("latency_clocks", cyc - t_grant, 32'd4);
        check("done3_slot", {24'd0, obs_bus}, 32'h20);
      end
    end
    check("done3_seen", (n_done > 0) ? 32'd1 : 32'd0, 32'd1);
    n_req = 8'h00;

    // Wait statistics: cog 5 starts requesting while cog 6 owns the slot.
    do_reset();
    n_sel = 3'd5;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (m_phase == 1 && m_owner == 6) found = 1;
      else step();
    end
    check("reach_slot6", found, 32'd1);
    n_req = 8'h20;
    for (int i = 0; i < 20; i++) step();
    check("wait5_max", {24'd0, obs_wq}, 32'd7);
    n_req = 8'h00;
    step();
    if (m_phase == 0) step();
    n_clr = 1'b1;
    step();
    n_clr = 1'b0;
    step();
    check("wait_clr", {24'd0, obs_wq}, 32'd0);

    // Lone requester in skip mode, with cog_ena toggling.
    n_skip = 1'b1; n_ena = 8'h04; n_req = 8'h04; n_sel = 3'd2;
    for (int i = 0; i < 20; i++) step();
    for (int i = 0; i < 20; i++) begin
      n_ena = (i % 3 == 0) ? 8'h00 : 8'h04;
      step();
    end

    // Reset one clock after a grant to cog 1: its result must never appear.
    n_skip = 1'b0; n_ena = 8'hFF; n_req = 8'h02;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (obs_grant[1]) found = 1;
    end
    check("grant1_seen", found, 32'd1);
    n_res = 1'b1;
    step();
    step();
    n_res = 1'b0; n_req = 8'h00; n_sel = 3'd1;
    step();
    check("post_rst_bus", {24'd0, obs_bus}, 32'h01);
    check("post_rst_wq",  {24'd0, obs_wq},  32'h00);
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (obs_done[1]) n_done++;
    end
    check("no_done1", n_done, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      n_req = 8'($urandom);
      n_ena = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 15) == 0) n_skip = ~n_skip;
      n_clr = ($urandom_range(0, 31) == 0);
      n_res = ($urandom_range(0, 199) == 0);
      n_sel = 3'($urandom);
      step();
    end
    n_res = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
